// File: rtl/shift_tx_pkg.sv
// Shared types and constants for the shift_tx serial transmitter.
// Holds the FSM state encoding, the parity modes and the bit-period counter width.
package shift_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Wide enough for BIT_CYCLES up to 255.
    localparam int CNT_W = 8;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while run is high and wraps.
// tick marks the last cycle of each bit period.
module bit_timer
    import shift_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic c,
    input  logic rst,
    input  logic run,
    output logic tick
);

    logic [CNT_W-1:0] r_cnt;

    assign tick = run && (r_cnt == CNT_W'(BIT_CYCLES - 1));

    // Held at zero outside a frame so the first START cycle is always count 0.
    always_ff @(posedge c) begin
        if (rst || !run) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_tx.sv
// Serial transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Every output is a register loaded from the next-state decode, so load never reaches q combinationally.
module shift_tx
    import shift_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int PARITY     = 0
) (
    input  logic       c,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       load,
    output logic       ready,
    output logic       q,
    output logic       busy,
    output logic       done
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_sr;
    logic [7:0] w_sr_nxt;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic       r_par;
    logic       w_par_nxt;
    logic       r_q;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic       w_q_nxt;
    logic       w_done_nxt;
    logic       w_accept;
    logic       w_run;
    logic       w_tick;

    assign w_run    = (r_state != IDLE);
    assign w_accept = load && r_ready;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .c   (c),
        .rst (rst),
        .run (w_run),
        .tick(w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_idx_nxt   = r_idx;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = START;
                    w_sr_nxt    = d;
                    w_idx_nxt   = 3'd0;
                    w_par_nxt   = (PARITY == PAR_ODD) ? ~^d : ^d;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_idx == 3'd7) begin
                        w_state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                        w_sr_nxt  = r_sr >> 1;
                    end
                end
            end
            PAR: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level follows the state being entered, so q changes on the same edge as the state.
    always_comb begin
        w_q_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_q_nxt = 1'b0;
            DATA:    w_q_nxt = w_sr_nxt[0];
            PAR:     w_q_nxt = w_par_nxt;
            default: w_q_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge c) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_q     <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_idx   <= w_idx_nxt;
            r_par   <= w_par_nxt;
            r_q     <= w_q_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign q     = r_q;
    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_shift_tx.sv
// Directed and random frames on four shift_tx configurations against a bit-list reference model.
module tb_shift_tx;

    logic       c;
    logic       rst;
    logic [7:0] dd;
    logic       ld    [4];
    logic       w_q   [4];
    logic       w_rdy [4];
    logic       w_busy[4];
    logic       w_done[4];

    int bc  [4] = '{4, 4, 4, 1};
    int par [4] = '{0, 1, 2, 0};
    int total = 0;
    int bad   = 0;

    shift_tx #(.BIT_CYCLES(4), .PARITY(0)) u0 (
        .c(c), .rst(rst), .d(dd), .load(ld[0]),
        .ready(w_rdy[0]), .q(w_q[0]), .busy(w_busy[0]), .done(w_done[0]));
    shift_tx #(.BIT_CYCLES(4), .PARITY(1)) u1 (
        .c(c), .rst(rst), .d(dd), .load(ld[1]),
        .ready(w_rdy[1]), .q(w_q[1]), .busy(w_busy[1]), .done(w_done[1]));
    shift_tx #(.BIT_CYCLES(4), .PARITY(2)) u2 (
        .c(c), .rst(rst), .d(dd), .load(ld[2]),
        .ready(w_rdy[2]), .q(w_q[2]), .busy(w_busy[2]), .done(w_done[2]));
    shift_tx #(.BIT_CYCLES(1), .PARITY(0)) u3 (
        .c(c), .rst(rst), .d(dd), .load(ld[3]),
        .ready(w_rdy[3]), .q(w_q[3]), .busy(w_busy[3]), .done(w_done[3]));

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s u%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    // Called in the first START cycle; returns in the done cycle, or just after an abort.
    task automatic run_frame(input int k, input logic [7:0] data, input int pulse_at, input int abort_at);
        bit exp[$];
        int n;
        exp.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp.push_back(data[b]);
        if (par[k] == 1) exp.push_back(^data);
        if (par[k] == 2) exp.push_back(~^data);
        exp.push_back(1'b1);
        n = exp.size() * bc[k];
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_q", k, w_q[k], 1'b1);
                chk("abort_ready", k, w_rdy[k], 1'b1);
                chk("abort_busy", k, w_busy[k], 1'b0);
                chk("abort_done", k, w_done[k], 1'b0);
                for (int j = 0; j < 3 * bc[k]; j++) begin
                    tick();
                    chk("post_abort_done", k, w_done[k], 1'b0);
                    chk("post_abort_q", k, w_q[k], 1'b1);
                end
                return;
            end
            chk("q", k, w_q[k], exp[i / bc[k]]);
            chk("busy", k, w_busy[k], 1'b1);
            chk("ready", k, w_rdy[k], 1'b0);
            chk("done_early", k, w_done[k], 1'b0);
            if (i == pulse_at) begin
                ld[k] = 1'b1;
                dd = 8'hFF;
            end
            tick();
            if (i == pulse_at) ld[k] = 1'b0;
        end
        chk("done", k, w_done[k], 1'b1);
        chk("idle_q", k, w_q[k], 1'b1);
        chk("idle_ready", k, w_rdy[k], 1'b1);
        chk("idle_busy", k, w_busy[k], 1'b0);
    endtask

    task automatic send(input int k, input logic [7:0] data, input int pulse_at, input int abort_at);
        ld[k] = 1'b1;
        dd = data;
        tick();
        ld[k] = 1'b0;
        dd = 8'($urandom);
        run_frame(k, data, pulse_at, abort_at);
        if (abort_at < 0) begin
            tick();
            chk("done_one_cycle", k, w_done[k], 1'b0);
            chk("stays_idle", k, w_busy[k], 1'b0);
            chk("idle_q2", k, w_q[k], 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        dd  = 8'h00;
        for (int k = 0; k < 4; k++) ld[k] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rst_q", k, w_q[k], 1'b1);
            chk("rst_ready", k, w_rdy[k], 1'b1);
            chk("rst_busy", k, w_busy[k], 1'b0);
            chk("rst_done", k, w_done[k], 1'b0);
        end

        // Reset wins over a simultaneous load.
        rst = 1'b1;
        ld[0] = 1'b1;
        dd = 8'h55;
        tick();
        rst = 1'b0;
        ld[0] = 1'b0;
        chk("rst_prio_busy", 0, w_busy[0], 1'b0);
        chk("rst_prio_q", 0, w_q[0], 1'b1);
        tick();
        chk("rst_prio_busy2", 0, w_busy[0], 1'b0);

        send(0, 8'hA5, -1, -1);
        send(1, 8'h07, -1, -1);
        send(2, 8'h07, -1, -1);
        send(3, 8'h00, -1, -1);

        // Load held high across two words: one idle cycle between frames.
        ld[0] = 1'b1;
        dd = 8'h3C;
        tick();
        dd = 8'hC3;
        run_frame(0, 8'h3C, -1, -1);
        tick();
        run_frame(0, 8'hC3, -1, -1);
        ld[0] = 1'b0;
        tick();
        chk("b2b_done_once", 0, w_done[0], 1'b0);
        chk("b2b_idle", 0, w_busy[0], 1'b0);

        send(0, 8'h96, 12, -1);
        send(0, 8'h96, -1, 17);
        send(0, 8'h5A, -1, -1);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                send(k, 8'($urandom), -1, -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
